// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into press/release/short/long/repeat pulses.
module button_event_gen #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 12500000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);
  typedef enum logic [1:0] {LOCKOUT, IDLE, PRESSED, HELD} state_t;
  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d, rep_cnt_q, rep_cnt_d;
  logic press_q, press_d, release_q, release_d, short_q, short_d;
  logic long_q, long_d, repeat_q, repeat_d, held_q, held_d;
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    short_d     = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;
    case (state_q)
      LOCKOUT: state_d = btn_level ? LOCKOUT : IDLE;
      IDLE: if (btn_level) begin
        state_d     = PRESSED;
        press_cnt_d = CNT_W'(1);
        press_d     = 1'b1;
      end
      PRESSED: if (!btn_level) begin
        state_d   = IDLE;
        release_d = 1'b1;
        short_d   = 1'b1;
      end else if (press_cnt_q == LONG_T) begin
        state_d   = HELD;
        long_d    = 1'b1;
        rep_cnt_d = '0;
      end else begin
        press_cnt_d = press_cnt_q + 1'b1;
      end
      HELD: if (!btn_level) begin
        state_d   = IDLE;
        release_d = 1'b1;
      end else if (rep_cnt_q == REP_T) begin
        // counter runs regardless of repeat_en so the cadence phase survives gating
        rep_cnt_d = '0;
        repeat_d  = repeat_en;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
      default: state_d = LOCKOUT;
    endcase
    held_d = (state_d == HELD);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOCKOUT;
      press_cnt_q <= '0;
      rep_cnt_q   <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      short_q     <= short_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
      held_q      <= held_d;
    end
  end
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: directed and random stimulus against a run-length reference model.
module tb_button_event_gen;
  localparam int L = 4;
  localparam int R = 3;
  logic clk = 1'b0;
  logic rst_n, btn_level, repeat_en;
  logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
  int checks = 0;
  int errors = 0;
  bit armed = 0;
  int run = 0;
  button_event_gen #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .repeat_en(repeat_en),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .short_pulse(short_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held)
  );
  always #5 clk = ~clk;
  // model: run = consecutive high samples of the current recognised press
  task automatic step(input logic b, input logic e, input logic r, input string t);
    logic [5:0] obs, exp;
    btn_level = b;
    repeat_en = e;
    rst_n = r;
    @(posedge clk);
    #1;
    exp = '0;
    if (!r) begin
      armed = 0;
      run = 0;
    end else if (!armed) begin
      if (!b) armed = 1;
    end else if (b) begin
      run++;
      exp[5] = (run == 1);
      exp[2] = (run == L);
      exp[1] = (run > L) && ((run - L) % R == 0) && e;
      exp[0] = (run >= L);
    end else begin
      if (run > 0) begin
        exp[4] = 1'b1;
        exp[3] = (run < L);
      end
      run = 0;
    end
    obs = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs(p,r,s,l,rp,h)=%b exp=%b", t, obs, exp);
    end
  endtask
  task automatic hold(input int n, input logic b, input string t);
    for (int i = 0; i < n; i++) step(b, 1'b1, 1'b1, t);
  endtask
  initial begin
    step(1'b1, 1'b1, 1'b0, "reset");
    hold(10, 1'b1, "lockout_held");
    hold(2, 1'b0, "lockout_release");
    hold(1, 1'b1, "first_press");
    hold(3, 1'b0, "first_release");
    hold(2, 1'b1, "short2_high");
    hold(2, 1'b0, "short2_low");
    hold(12, 1'b1, "hold12_high");
    hold(2, 1'b0, "hold12_low");
    hold(4, 1'b1, "long4_high");
    hold(2, 1'b0, "long4_low");
    hold(3, 1'b1, "short3_high");
    hold(2, 1'b0, "short3_low");
    for (int i = 1; i <= 12; i++) step(1'b1, !(i >= 6 && i <= 8), 1'b1, "gated_repeat");
    hold(2, 1'b0, "gated_low");
    hold(6, 1'b1, "held_before_reset");
    step(1'b1, 1'b1, 1'b0, "reset_in_held");
    hold(3, 1'b1, "post_reset_high");
    hold(2, 1'b0, "post_reset_low");
    hold(2, 1'b1, "post_reset_press");
    hold(2, 1'b0, "post_reset_release");
    for (int k = 0; k < 300; k++) begin
      int len = $urandom_range(1, 14);
      int rc = ($urandom_range(0, 19) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int i = 0; i < len; i++)
        step(1'b1, $urandom_range(0, 3) != 0, i != rc, "rand_high");
      for (int i = $urandom_range(1, 3); i > 0; i--)
        step(1'b0, $urandom_range(0, 1) == 1, 1'b1, "rand_low");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Consumes the clean, debounced button level from the button debouncer and turns it into single-cycle event pulses for the clock's time-setting control logic.
- Event pulses: press, release, short click, long press, and auto-repeat while held.
- One instance per front-panel button.
- Sits directly downstream of the debouncer and upstream of the set/mode FSM.

Parameters:
- LONG_CYCLES, default 50000000: number of consecutive high samples (including the first) that qualify as a long press. Must be >= 2.
- REPEAT_CYCLES, default 12500000: high samples between successive auto-repeat pulses once a long press has been recognised. Must be >= 1.
- CNT_W, default 26: counter width. Must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- btn_level  input  1  debounced button level, 1 = pressed; already synchronous to clk
- repeat_en  input  1  1 = emit auto-repeat pulses in HELD; sampled each cycle
- press_pulse  output  1  one-cycle pulse on recognised press
- release_pulse  output  1  one-cycle pulse on any release following a recognised press
- short_pulse  output  1  one-cycle pulse on release before long-press threshold
- long_pulse  output  1  one-cycle pulse when long-press threshold reached
- repeat_pulse  output  1  one-cycle auto-repeat pulse
- held  output  1  level, 1 while in HELD state

Behaviour:
- Design style:
  - Single clock domain.
  - All outputs registered.
  - Every response appears one cycle after the clk edge on which the causing btn_level value is sampled.
- Reset (rst_n=0 at a clk edge):
  - state <= LOCKOUT.
  - Press counter and repeat counter <= 0.
  - All outputs <= 0.
  - Reset mid-press aborts with no release/short pulse.
- States:
  - LOCKOUT:
    - Ignores a button already held at reset release.
    - btn_level=0 -> IDLE.
    - btn_level=1 -> stay.
    - No pulses.
  - IDLE:
    - btn_level=1 -> PRESSED, press counter <= 1, press_pulse=1.
    - btn_level=0 -> stay.
  - PRESSED, on btn_level=0:
    - -> IDLE.
    - release_pulse=1 and short_pulse=1 in the same cycle.
  - PRESSED, on btn_level=1 with press counter == LONG_CYCLES-1:
    - -> HELD, long_pulse=1, repeat counter <= 0.
  - PRESSED, on btn_level=1 otherwise:
    - press counter +1.
  - HELD, on btn_level=0:
    - -> IDLE, release_pulse=1.
    - No short_pulse, no repeat_pulse.
  - HELD, on btn_level=1 with repeat counter == REPEAT_CYCLES-1:
    - repeat counter <= 0.
    - repeat_pulse=repeat_en.
  - HELD, on btn_level=1 otherwise:
    - repeat counter +1.
- Timing consequences:
  - long_pulse follows the LONG_CYCLES-th consecutive high sample.
  - The first repeat follows REPEAT_CYCLES further high samples, then every REPEAT_CYCLES samples.
- Pulse rules:
  - Every pulse output is high for exactly one cycle.
  - A sample of 0 always wins over a coincident counter terminal value: release is reported and long/repeat are suppressed.
  - Per cycle, at most one of press/long/repeat/release is high; short_pulse only accompanies release_pulse.
- repeat_en:
  - Gates only repeat_pulse.
  - The repeat counter keeps running while repeat_en=0, so cadence phase is preserved when it is re-enabled.
- Counter arithmetic and wrap:
  - Counters are unsigned CNT_W bits.
  - They never wrap, because they are reset at their terminal values.
  - The press counter is held, not incremented, outside PRESSED.
- held is 1 exactly while state is HELD.

Test Plan:
- Common parameters, used wherever not stated otherwise: LONG_CYCLES=4, REPEAT_CYCLES=3, repeat_en=1.
- Reset with btn_level=1, held 10 cycles, then 0, then 1:
  - No pulses while held after reset.
  - Release gives no pulse.
  - Next rise gives press_pulse one cycle later.
- btn_level high for exactly 2 samples from IDLE:
  - press_pulse after sample 1.
  - release_pulse and short_pulse together after the first low sample.
  - long_pulse never asserted.
- btn_level high for 12 samples:
  - press_pulse after sample 1.
  - long_pulse and held=1 after sample 4.
  - repeat_pulse after samples 7 and 10.
  - release_pulse only after sample 13 (low); held drops to 0.
- btn_level high for exactly 4 samples, then low:
  - long_pulse after sample 4.
  - Release gives release_pulse without short_pulse.
  - Boundary: 3 samples gives short_pulse instead.
- Held 12 samples, with repeat_en=0 during samples 6-8:
  - No repeat at sample 7.
  - repeat_pulse at sample 10, proving the counter kept running.
- rst_n=0 for one cycle while in HELD:
  - All outputs 0 next cycle, held=0.
  - No release_pulse when btn_level later drops.
